// File: rtl/chi_pkg.sv
// chi_pkg: shared CHI link-layer types and constants
// Provides the link state enum, the ReqLCrdReturn opcode and the opcode field position.
package chi_pkg;
   typedef enum logic [2:0] {STOP, ACTIVATE, RUN, DEACT, RETURN} chi_link_state_e;
   localparam logic [6:0] REQ_LCRD_RETURN = 7'h00;
   localparam int REQ_OPCODE_LSB = 0;
   localparam int REQ_OPCODE_MSB = 6;
   localparam int CHI_MAX_LCRD = 15;
endpackage

// File: rtl/chi_flit_fifo.sv
// chi_flit_fifo: synchronous FIFO for request flits
// Ports: clk, resetn (sync active-low), push/din write side, pop/dout read side
// (dout shows the head entry), full/empty status.
module chi_flit_fifo #(
   parameter int WIDTH = 100,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0] wptr, rptr;
   assign empty = wptr == rptr;
   assign full = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign dout = mem[rptr[AW-1:0]];
   always_ff @(posedge clk) begin
      if (!resetn) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (push && !full) begin
            mem[wptr[AW-1:0]] <= din;
            wptr <= wptr + 1'b1;
         end
         if (pop && !empty) rptr <= rptr + 1'b1;
      end
   end
endmodule

// File: rtl/chi_req_tx_link.sv
// chi_req_tx_link: CHI-B REQ channel TX link layer with credit tracking
// Ports: clk, resetn (sync active-low), link_en/link_active link control,
// up_valid/up_ready/up_flit upstream flits, reqflitpend/reqflitv/req_flit CHI REQ channel,
// reqlcrdv incoming credits, credit_cnt credits held, err_credit sticky credit error.
module chi_req_tx_link
   import chi_pkg::*;
#(
   parameter int REQ_FLIT_WIDTH = 100,
   parameter int FIFO_DEPTH = 4,
   parameter int MAX_CREDITS = CHI_MAX_LCRD,
   localparam int CRED_W = $clog2(MAX_CREDITS + 1)
) (
   input  logic                      clk,
   input  logic                      resetn,
   input  logic                      link_en,
   output logic                      link_active,
   input  logic                      up_valid,
   output logic                      up_ready,
   input  logic [REQ_FLIT_WIDTH-1:0] up_flit,
   output logic                      reqflitpend,
   output logic                      reqflitv,
   output logic [REQ_FLIT_WIDTH-1:0] req_flit,
   input  logic                      reqlcrdv,
   output logic [CRED_W-1:0]         credit_cnt,
   output logic                      err_credit
);
   chi_link_state_e state, state_next;
   logic fifo_full, fifo_empty, send, ret, consume, grant, err_set;
   logic [REQ_FLIT_WIDTH-1:0] fifo_dout, ret_flit;
   logic [CRED_W-1:0] cnt_next;
   chi_flit_fifo #(.WIDTH(REQ_FLIT_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(clk), .resetn(resetn), .push(up_valid && up_ready), .din(up_flit),
      .pop(send), .dout(fifo_dout), .full(fifo_full), .empty(fifo_empty)
   );
   assign up_ready = (state == RUN) && !fifo_full;
   always_comb begin
      state_next = state;
      send = !fifo_empty && (credit_cnt != '0) && (state == RUN || state == DEACT);
      ret = (state == RETURN) && (credit_cnt != '0);
      consume = send || ret;
      // grants while STOP are never banked
      grant = reqlcrdv && (state != STOP);
      err_set = reqlcrdv && (state == STOP || (credit_cnt == CRED_W'(MAX_CREDITS) && !consume));
      cnt_next = (grant && !consume) ? ((credit_cnt == CRED_W'(MAX_CREDITS)) ? credit_cnt : credit_cnt + 1'b1) :
                 (!grant && consume) ? credit_cnt - 1'b1 : credit_cnt;
      ret_flit = '0;
      ret_flit[REQ_OPCODE_MSB:REQ_OPCODE_LSB] = REQ_LCRD_RETURN;
      case (state)
         STOP:     state_next = link_en ? ACTIVATE : STOP;
         ACTIVATE: state_next = reqlcrdv ? RUN : (!link_en && credit_cnt == '0) ? STOP : ACTIVATE;
         RUN:      state_next = link_en ? RUN : DEACT;
         DEACT:    state_next = (fifo_empty && !send) ? RETURN : DEACT;
         RETURN:   state_next = (credit_cnt == '0 && !reqlcrdv) ? STOP : RETURN;
         default:  state_next = STOP;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state <= STOP;
         credit_cnt <= '0;
         err_credit <= 1'b0;
         reqflitv <= 1'b0;
         req_flit <= '0;
         reqflitpend <= 1'b0;
         link_active <= 1'b0;
      end else begin
         state <= state_next;
         credit_cnt <= cnt_next;
         err_credit <= err_credit || err_set;
         reqflitv <= consume;
         if (consume) req_flit <= send ? fifo_dout : ret_flit;
         // status outputs registered from the next state so they track the state register exactly
         reqflitpend <= state_next != STOP;
         link_active <= state_next == RUN;
      end
   end
endmodule

// File: tb/tb_chi_req_tx_link.sv
// tb_chi_req_tx_link: directed and random checks of chi_req_tx_link against a queue-based model
module tb_chi_req_tx_link;
   localparam int W = 100;
   localparam int M_STOP = 0, M_ACT = 1, M_RUN = 2, M_DEACT = 3, M_RET = 4;
   logic clk = 1'b0;
   logic resetn = 1'b0, link_en = 1'b0, up_valid = 1'b0, reqlcrdv = 1'b0;
   logic [W-1:0] up_flit = '0;
   logic link_active, up_ready, reqflitpend, reqflitv, err_credit;
   logic [W-1:0] req_flit;
   logic [3:0] credit_cnt;
   int checks = 0, errors = 0;
   int m_st = M_STOP, m_cnt = 0;
   bit m_err = 0, m_v = 0;
   logic [W-1:0] m_flit = '0;
   logic [W-1:0] q [$];

   chi_req_tx_link dut (
      .clk(clk), .resetn(resetn), .link_en(link_en), .link_active(link_active),
      .up_valid(up_valid), .up_ready(up_ready), .up_flit(up_flit),
      .reqflitpend(reqflitpend), .reqflitv(reqflitv), .req_flit(req_flit),
      .reqlcrdv(reqlcrdv), .credit_cnt(credit_cnt), .err_credit(err_credit)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] rnd_flit();
      return W'({$urandom, $urandom, $urandom, $urandom});
   endfunction

   // one clock: advance the model with the inputs present before the edge, then compare
   task automatic step();
      bit ready, send, ret;
      int nst, ncnt;
      if (!resetn) begin
         q.delete();
         m_st = M_STOP; m_cnt = 0; m_err = 0; m_v = 0; m_flit = '0;
      end else begin
         ready = (m_st == M_RUN) && (q.size() < 4);
         send = (q.size() > 0) && (m_cnt > 0) && (m_st == M_RUN || m_st == M_DEACT);
         ret = (m_st == M_RET) && (m_cnt > 0);
         nst = m_st;
         case (m_st)
            M_STOP:  if (link_en) nst = M_ACT;
            M_ACT:   if (reqlcrdv) nst = M_RUN; else if (!link_en && m_cnt == 0) nst = M_STOP;
            M_RUN:   if (!link_en) nst = M_DEACT;
            M_DEACT: if (q.size() == 0) nst = M_RET;
            default: if (m_cnt == 0 && !reqlcrdv) nst = M_STOP;
         endcase
         m_v = send || ret;
         if (send) m_flit = q.pop_front();
         else if (ret) m_flit = '0;
         if (up_valid && ready) q.push_back(up_flit);
         if (m_st == M_STOP) begin
            if (reqlcrdv) m_err = 1;
         end else begin
            ncnt = m_cnt + int'(reqlcrdv) - int'(m_v);
            if (ncnt > 15) begin
               ncnt = 15;
               m_err = 1;
            end
            m_cnt = ncnt;
         end
         m_st = nst;
      end
      @(posedge clk);
      #1;
      check("reqflitv", reqflitv, m_v);
      if (m_v) check("req_flit", req_flit, m_flit);
      check("credit_cnt", credit_cnt, m_cnt);
      check("err_credit", err_credit, m_err);
      check("reqflitpend", reqflitpend, m_st != M_STOP);
      check("link_active", link_active, m_st == M_RUN);
      check("up_ready", up_ready, (m_st == M_RUN) && (q.size() < 4));
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic push_n(input int n);
      up_valid = 1'b1;
      for (int i = 0; i < n; i++) begin
         up_flit = rnd_flit();
         step();
      end
      up_valid = 1'b0;
   endtask

   task automatic grant_n(input int n);
      reqlcrdv = 1'b1;
      steps(n);
      reqlcrdv = 1'b0;
   endtask

   initial begin
      resetn = 1'b0;
      steps(2);
      check("rst_v", reqflitv, 1'b0);
      check("rst_cnt", credit_cnt, 4'd0);
      resetn = 1'b1;
      link_en = 1'b1;
      step();
      grant_n(3);
      check("act_cnt3", credit_cnt, 4'd3);
      push_n(3);
      steps(4);
      check("abc_cnt0", credit_cnt, 4'd0);
      push_n(4);
      up_valid = 1'b1;
      up_flit = rnd_flit();
      step();
      check("full_ready", up_ready, 1'b0);
      up_valid = 1'b0;
      grant_n(1);
      step();
      check("one_sent_ready", up_ready, 1'b1);
      grant_n(2);
      check("same_cycle_cnt", credit_cnt, 4'd1);
      steps(3);
      grant_n(18);
      check("sat_cnt", credit_cnt, 4'd15);
      check("sat_err", err_credit, 1'b1);
      steps(3);
      check("err_sticky", err_credit, 1'b1);
      resetn = 1'b0;
      link_en = 1'b0;
      step();
      check("rst_err", err_credit, 1'b0);
      resetn = 1'b1;
      link_en = 1'b1;
      step();
      grant_n(5);
      up_valid = 1'b1;
      up_flit = rnd_flit();
      step();
      up_flit = rnd_flit();
      link_en = 1'b0;
      step();
      up_valid = 1'b0;
      steps(10);
      check("deact_pend", reqflitpend, 1'b0);
      check("deact_cnt", credit_cnt, 4'd0);
      link_en = 1'b1;
      step();
      grant_n(1);
      push_n(1);
      step();
      push_n(3);
      resetn = 1'b0;
      step();
      check("midrst_v", reqflitv, 1'b0);
      check("midrst_pend", reqflitpend, 1'b0);
      resetn = 1'b1;
      step();
      grant_n(3);
      for (int i = 0; i < 4; i++) begin
         step();
         check("stale", reqflitv, 1'b0);
      end
      for (int i = 0; i < 3000; i++) begin
         resetn = $urandom_range(0, 199) != 0;
         if ($urandom_range(0, 39) == 0) link_en = !link_en;
         up_valid = $urandom_range(0, 1) == 1;
         up_flit = rnd_flit();
         reqlcrdv = $urandom_range(0, 2) == 0;
         step();
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
